// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: per-channel state encoding
// and the width helper used to size the channel timer.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_HIGH = 2'd1,
        PS_LOW  = 2'd2
    } ps_state_e;

    function automatic int ps_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/pulse_stretcher_channel.sv
// One stretcher channel: IDLE/HIGH/LOW FSM, cycle timer and a saturating
// count of events that arrived while the channel was busy.
module pulse_stretcher_channel
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_CYCLES   = 4,
    parameter int LOW_CYCLES    = 3,
    parameter int PENDING_WIDTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic in_i,
    input  logic clear_overflow_i,
    output logic out_o,
    output logic busy_o,
    output logic overflow_o
);

    localparam int TMAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int TW   = ps_clog2(TMAX) + 1;
    localparam logic [TW-1:0] T_HIGH = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] T_LOW  = TW'(LOW_CYCLES - 1);
    localparam logic [PENDING_WIDTH-1:0] PMAX = {PENDING_WIDTH{1'b1}};

    ps_state_e               state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [PENDING_WIDTH-1:0] pend_q, pend_d;
    logic                    ovf_q, ovf_d;
    logic                    out_q, busy_q;
    logic                    consume, drop;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        consume = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            PS_IDLE: begin
                if (in_i) begin
                    state_d = PS_HIGH;
                    timer_d = T_HIGH;
                end
            end
            PS_HIGH: begin
                if (timer_q == '0) begin
                    state_d = PS_LOW;
                    timer_d = T_LOW;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            PS_LOW: begin
                // Re-arm straight from the last LOW cycle so back-to-back
                // pulses are separated by exactly LOW_CYCLES.
                if (timer_q == '0) begin
                    if ((pend_q != '0) || in_i) begin
                        state_d = PS_HIGH;
                        timer_d = T_HIGH;
                        consume = 1'b1;
                    end else begin
                        state_d = PS_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = PS_IDLE;
        endcase

        // A consume that coincides with a new event swaps one for the other.
        if (consume && !in_i) begin
            pend_d = pend_q - 1'b1;
        end else if (in_i && (state_q != PS_IDLE) && !consume) begin
            if (pend_q == PMAX) drop = 1'b1;
            else                pend_d = pend_q + 1'b1;
        end

        ovf_d = drop | (ovf_q & ~clear_overflow_i);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PS_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= (state_d == PS_HIGH);
            busy_q  <= (state_d != PS_IDLE) || (pend_d != '0);
        end
    end

    assign out_o      = out_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Converts single-cycle event strobes into fixed-width, guaranteed-gap level
// pulses; WIDTH fully independent channels.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int HIGH_CYCLES   = 4,
    parameter int LOW_CYCLES    = 3,
    parameter int PENDING_WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_i,
    input  logic [WIDTH-1:0] clear_overflow_i,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] busy_o,
    output logic [WIDTH-1:0] overflow_o
);

    if (WIDTH < 1 || HIGH_CYCLES < 1 || LOW_CYCLES < 1 || PENDING_WIDTH < 1) begin : g_bad_param
        $error("pulse_stretcher: illegal parameter value");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pulse_stretcher_channel #(
            .HIGH_CYCLES  (HIGH_CYCLES),
            .LOW_CYCLES   (LOW_CYCLES),
            .PENDING_WIDTH(PENDING_WIDTH)
        ) u_ch (
            .clock           (clock),
            .reset           (reset),
            .in_i            (in_i[i]),
            .clear_overflow_i(clear_overflow_i[i]),
            .out_o           (out_o[i]),
            .busy_o          (busy_o[i]),
            .overflow_o      (overflow_o[i])
        );
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: per-cycle input patterns are replayed and the resulting
// out/busy/overflow traces compared with hand-derived waveforms.
module tb_pulse_stretcher;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_i  = '0;
    logic [W-1:0] clr_i = '0;
    logic [W-1:0] out_o, busy_o, ovf_o;

    int checks = 0;
    int errors = 0;

    pulse_stretcher #(
        .WIDTH(W), .HIGH_CYCLES(4), .LOW_CYCLES(3), .PENDING_WIDTH(2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_i            (in_i),
        .clear_overflow_i(clr_i),
        .out_o           (out_o),
        .busy_o          (busy_o),
        .overflow_o      (ovf_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_i  = '0;
        clr_i = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Bit (n-1-k) of each pattern is driven before edge k; traces collect
    // the output after each edge, first sample ending up most significant.
    task automatic run(input int n,
                       input logic [W-1:0][63:0] ip,
                       input logic [W-1:0][63:0] cp,
                       input logic [63:0] rp,
                       output logic [W-1:0][63:0] ot,
                       output logic [W-1:0][63:0] bt,
                       output logic [W-1:0][63:0] vt);
        ot = '0; bt = '0; vt = '0;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < W; c++) begin
                in_i[c]  = ip[c][n-1-k];
                clr_i[c] = cp[c][n-1-k];
            end
            reset = rp[n-1-k];
            tick();
            for (int c = 0; c < W; c++) begin
                ot[c] = {ot[c][62:0], out_o[c]};
                bt[c] = {bt[c][62:0], busy_o[c]};
                vt[c] = {vt[c][62:0], ovf_o[c]};
            end
        end
        in_i  = '0;
        clr_i = '0;
        reset = 1'b0;
    endtask

    logic [W-1:0][63:0] ip, cp, ot, bt, vt;

    initial begin
        // Reset state, with in held high to show it is discarded.
        reset = 1'b1;
        in_i  = '1;
        tick();
        tick();
        chk("rst_out",  64'(out_o),  64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_ovf",  64'(ovf_o),  64'h0);
        reset = 1'b0;
        in_i  = '0;
        tick();
        chk("post_rst_out",  64'(out_o),  64'h0);
        chk("post_rst_busy", 64'(busy_o), 64'h0);

        // 1: single event
        do_reset();
        ip = '0; cp = '0;
        ip[0] = 64'(10'b1000000000);
        run(10, ip, cp, 64'h0, ot, bt, vt);
        chk("t1_out",  ot[0], 64'(10'b1111000000));
        chk("t1_busy", bt[0], 64'(10'b1111111000));
        chk("t1_ovf",  vt[0], 64'h0);

        // 2: three consecutive events -> three pulses, 3-cycle gaps
        do_reset();
        ip = '0; cp = '0;
        ip[0] = 64'(24'hE00000);
        run(24, ip, cp, 64'h0, ot, bt, vt);
        chk("t2_out",  ot[0], 64'(24'hF1E3C0));
        chk("t2_busy", bt[0], 64'(24'hFFFFF8));
        chk("t2_ovf",  vt[0], 64'h0);

        // 3: five events (one dropped), clear, then clear+drop together
        do_reset();
        ip = '0; cp = '0;
        ip[0] = 64'(32'hFA000000);
        cp[0] = 64'(32'h06000000);
        run(32, ip, cp, 64'h0, ot, bt, vt);
        chk("t3_out",  ot[0], 64'(32'hF1E3C780));
        chk("t3_busy", bt[0], 64'(32'hFFFFFFF0));
        chk("t3_ovf",  vt[0], 64'(32'h0BFFFFFF));
        ip = '0; cp = '0;
        cp[0] = 64'(2'b10);
        run(2, ip, cp, 64'h0, ot, bt, vt);
        chk("t3_clr", vt[0], 64'h0);

        // 4: event on the final LOW cycle re-arms with no idle gap
        do_reset();
        ip = '0; cp = '0;
        ip[0] = 64'(16'h8100);
        run(16, ip, cp, 64'h0, ot, bt, vt);
        chk("t4_out",  ot[0], 64'(16'hF1E0));
        chk("t4_busy", bt[0], 64'(16'hFFFC));
        chk("t4_ovf",  vt[0], 64'h0);

        // 5: reset during second HIGH with pending=2, overflow=1
        do_reset();
        ip = '0; cp = '0;
        ip[0] = 64'(20'hF8000);
        run(20, ip, cp, 64'(20'h00800), ot, bt, vt);
        chk("t5_out",  ot[0], 64'(20'hF1000));
        chk("t5_busy", bt[0], 64'(20'hFF000));
        chk("t5_ovf",  vt[0], 64'(20'h0F000));

        // 6: channels 0 and 2 together, burst with overflow on channel 3
        do_reset();
        ip = '0; cp = '0;
        ip[0] = 64'(32'h80000000);
        ip[2] = 64'(32'h80000000);
        ip[3] = 64'(32'hF8000000);
        run(32, ip, cp, 64'h0, ot, bt, vt);
        chk("t6_out0",  ot[0], 64'(32'hF0000000));
        chk("t6_busy0", bt[0], 64'(32'hFE000000));
        chk("t6_ovf0",  vt[0], 64'h0);
        chk("t6_out1",  ot[1], 64'h0);
        chk("t6_busy1", bt[1], 64'h0);
        chk("t6_ovf1",  vt[1], 64'h0);
        chk("t6_out2",  ot[2], 64'(32'hF0000000));
        chk("t6_busy2", bt[2], 64'(32'hFE000000));
        chk("t6_ovf2",  vt[2], 64'h0);
        chk("t6_out3",  ot[3], 64'(32'hF1E3C780));
        chk("t6_busy3", bt[3], 64'(32'hFFFFFFF0));
        chk("t6_ovf3",  vt[3], 64'(32'h0FFFFFFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses into clean, fixed-width, guaranteed-gap level pulses, one channel per bit. It is the inverse of edge_to_pulse.
- Its output is slow enough to be captured by pipeline_synchronizer or slow_asynchronizer in a slower or unrelated clock domain.
- Events that arrive while a channel is busy are queued in a saturating per-channel counter. None are silently merged; losses are flagged.
- Sits on the source side of every single-bit event CDC path.

Parameters:
- WIDTH, 1, number of independent channels.
- HIGH_CYCLES, 4, out[i] high time in clock cycles; must be >=1.
- LOW_CYCLES, 3, minimum out[i] low time between consecutive stretched pulses; must be >=1.
- PENDING_WIDTH, 2, width of the per-channel pending-event counter; maximum queued events = 2**PENDING_WIDTH-1.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; dominates all other inputs.
- in  input  WIDTH  event strobe; each clock with in[i]=1 counts as one event.
- clear_overflow  input  WIDTH  clears overflow[i].
- out  output  WIDTH  registered stretched pulse.
- busy  output  WIDTH  1 when channel i is not IDLE or has pending events.
- overflow  output  WIDTH  sticky; an event was lost on channel i.

Behaviour:
- Interface (decided): one clock named clock; reset named reset, synchronous and active-high.
- Reset values: out=0, busy=0, overflow=0, every channel IDLE, counters=0, pending=0. in[i] sampled on a reset edge is discarded.
- Per-channel FSM states: IDLE, HIGH, LOW. out[i] is a registered decode of state==HIGH.
- IDLE:
  - in[i]=1 -> HIGH, timer=HIGH_CYCLES-1.
  - Latency: out[i] rises on the edge that samples in[i].
- HIGH:
  - timer decrements each cycle.
  - At timer==0 -> LOW, timer=LOW_CYCLES-1.
  - out[i] is high for exactly HIGH_CYCLES cycles.
- LOW: timer decrements each cycle. At timer==0:
  - if pending>0 or in[i]=1 -> HIGH, with the event consumed;
  - else -> IDLE.
  - out[i] is low for exactly LOW_CYCLES cycles between back-to-back pulses; no extra idle cycle is inserted.
- Pending counter update:
  - in[i]=1 in HIGH or LOW, not consumed that cycle: pending+1.
  - Consume while in[i]=0: pending-1.
  - Consume with in[i]=1: the new event replaces the consumed one; pending is unchanged.
- Saturation:
  - An increment with pending at maximum leaves pending at maximum and sets overflow[i]; that event is dropped.
  - A simultaneous consume never overflows.
- overflow[i]:
  - set by a drop, cleared by clear_overflow[i].
  - Set and clear in the same cycle: set wins.
- busy[i] = (state!=IDLE) | (pending!=0), registered-state decode with no combinational path from in.
- Output count: every accepted event yields exactly one out[i] pulse. N events with no overflow give N pulses.
- Channels share nothing but clock and reset. Behaviour of one channel is independent of all others.
- Reset mid-operation: on the edge where reset=1, out/busy/overflow return to 0 and pending is discarded. No pulse resumes afterwards.
- Widths: timer width = clog2(max(HIGH_CYCLES,LOW_CYCLES))+1. All arithmetic is unsigned and never wraps.
- Illegal parameters (HIGH_CYCLES<1, LOW_CYCLES<1, PENDING_WIDTH<1) halt elaboration.

Decomposition:
- Shared package/include holds:
  - state encoding constants PS_IDLE=2'd0, PS_HIGH=2'd1, PS_LOW=2'd2;
  - the clog2 helper function.
- Sub-module pulse_stretcher_channel (single bit, same parameters minus WIDTH) holds the FSM, timer and pending counter.
- Top generates WIDTH instances.

Test Plan (HIGH_CYCLES=4, LOW_CYCLES=3, PENDING_WIDTH=2 unless noted):
1. Single in pulse sampled at edge 10:
   - out=1 after edges 10..13, 0 after edge 14;
   - busy=1 after edges 10..16, 0 after edge 17;
   - overflow=0.
2. in high on 3 consecutive edges from an idle channel:
   - exactly 3 out pulses, each 4 high, separated by exactly 3 low;
   - pending peaks at 2;
   - busy falls 3 cycles after the last falling edge of out.
3. Five events all during the first HIGH:
   - pending saturates at 3 and overflow=1 on the 5th event;
   - exactly 4 out pulses;
   - clear_overflow=1 for one cycle -> overflow=0;
   - clear_overflow asserted together with a 6th dropped event -> overflow stays 1.
4. Single event sampled on the final LOW cycle with pending=0:
   - out rises on that edge, with no IDLE cycle between pulses;
   - pending remains 0.
5. reset asserted during HIGH with pending=2 and overflow=1:
   - after that edge out=0, busy=0, overflow=0;
   - no further pulses after reset deasserts.
6. WIDTH=4, events on channels 0 and 2 in the same cycle and a burst on channel 3:
   - per-channel waveforms identical to single-channel runs;
   - channels 1 and 2 unaffected by channel 3 overflow.
